// File: rtl/seq_multiplier8_pkg.sv
// Shared definitions for the sequential 8x8 multiplier: FSM encoding and iteration count.
package seq_multiplier8_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } mul_state_e;

    localparam int unsigned MulIter = 8;
    localparam int unsigned CountW  = $clog2(MulIter);

    // Value of the iteration counter on the final add/shift step.
    localparam logic [CountW-1:0] LastIter = CountW'(MulIter - 1);

endpackage

// File: rtl/FullAdder8.sv
// 8-bit ripple-carry adder shared with the ALU datapath.
module FullAdder8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout
);

    logic [8:0] carry;

    // Ripple the carry bit by bit from Cin to Cout.
    always_comb begin
        carry[0] = Cin;
        S        = '0;
        for (int i = 0; i < 8; i++) begin
            S[i]       = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        Cout = carry[8];
    end

endmodule

// File: rtl/seq_multiplier8.sv
// Multi-cycle 8x8 unsigned shift-and-add multiplier: one add/shift per clock, 8 clocks per product.
module seq_multiplier8
    import seq_multiplier8_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 START,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   P,
    output logic                 Z,
    output logic                 OVF
);

    // The datapath is built around the fixed 8-bit adder; any other width is a build error.
    if (WIDTH != 8) begin : g_width_check
        $error("seq_multiplier8: WIDTH must be 8 to match FullAdder8");
    end

    mul_state_e         state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CountW-1:0]  count_q, count_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [WIDTH-1:0]   acc_shift;
    logic [WIDTH-1:0]   q_shift;

    // Partial product: add M to ACC when the current multiplier LSB is set.
    assign add_b = q_q[0] ? m_q : '0;

    FullAdder8 add_stage (
        .A    (acc_q),
        .B    (add_b),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (cout)
    );

    // {Cout, S, Q} shifted right by one; Cout lands in ACC[7] so nothing is lost.
    assign acc_shift = {cout, sum[WIDTH-1:1]};
    assign q_shift   = {sum[0], q_q[WIDTH-1:1]};

    // Next-state and datapath update; a START in the done cycle is accepted like in idle.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        count_d = count_q;
        p_d     = p_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (START) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                acc_d   = acc_shift;
                q_d     = q_shift;
                count_d = count_q + 1'b1;
                if (count_q == LastIter) begin
                    p_d     = {acc_shift, q_shift};
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous abort on reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            count_q <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            count_q <= count_d;
            p_q     <= p_d;
        end
    end

    // Status outputs decode directly from state and the held product.
    always_comb begin
        BUSY = (state_q == StRun);
        DONE = (state_q == StDone);
        P    = p_q;
        Z    = (p_q == '0);
        OVF  = |p_q[2*WIDTH-1:WIDTH];
    end

endmodule

// File: tb/tb_seq_multiplier8.sv
// Directed, table-driven bench for seq_multiplier8 plus hand-written multi-cycle sequences.
module tb_seq_multiplier8;

    logic        CLK;
    logic        nRST;
    logic        START;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        BUSY;
    logic        DONE;
    logic [15:0] P;
    logic        Z;
    logic        OVF;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic        z;
        logic        ovf;
    } vec_t;

    vec_t vecs[6];

    seq_multiplier8 #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .START (START),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .P     (P),
        .Z     (Z),
        .OVF   (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Start one operation, wait (bounded) for DONE, check latency, result and the DONE pulse width.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p,
                         input logic exp_z, input logic exp_ovf, input logic [15:0] prev_p);
        int cycles;
        @(negedge CLK);
        START = 1'b1;
        A     = a;
        B     = b;
        @(posedge CLK); #1;
        START = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        check("busy_after_start", 16'(BUSY), 16'd1);
        cycles = 0;
        while (!DONE && cycles < 20) begin
            @(posedge CLK); #1;
            cycles++;
            if (cycles == 4) check("p_stable_while_busy", P, prev_p);
        end
        check("latency", 16'(cycles), 16'd8);
        check("product", P, exp_p);
        check("zero_flag", 16'(Z), 16'(exp_z));
        check("ovf_flag", 16'(OVF), 16'(exp_ovf));
        check("busy_at_done", 16'(BUSY), 16'd0);
        @(posedge CLK); #1;
        check("done_one_cycle", 16'(DONE), 16'd0);
        check("idle_after_done", 16'(BUSY), 16'd0);
    endtask

    initial begin
        int done_cnt;
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{a: 8'h0C, b: 8'h0A, p: 16'h0078, z: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01, z: 1'b0, ovf: 1'b1};
        vecs[2] = '{a: 8'h00, b: 8'hB7, p: 16'h0000, z: 1'b1, ovf: 1'b0};
        vecs[3] = '{a: 8'h5A, b: 8'h00, p: 16'h0000, z: 1'b1, ovf: 1'b0};
        vecs[4] = '{a: 8'h01, b: 8'h80, p: 16'h0080, z: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 8'h80, b: 8'h02, p: 16'h0100, z: 1'b0, ovf: 1'b1};

        nRST  = 1'b1;
        START = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        #3 nRST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_busy", 16'(BUSY), 16'd0);
        check("reset_done", 16'(DONE), 16'd0);
        check("reset_p", P, 16'h0000);
        check("reset_z", 16'(Z), 16'd1);
        check("reset_ovf", 16'(OVF), 16'd0);
        nRST = 1'b1;

        // Table-driven products.
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].z, vecs[i].ovf,
                  (i == 0) ? 16'h0000 : vecs[i-1].p);
        end

        // START during RUN ignored; operand changes during RUN have no effect.
        @(negedge CLK);
        START = 1'b1;
        A     = 8'h03;
        B     = 8'h05;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge CLK);
            A     = (i == 3) ? 8'hFF : 8'($urandom);
            B     = (i == 3) ? 8'hFF : 8'($urandom);
            START = (i == 3);
            @(posedge CLK); #1;
            check("run_no_early_done", 16'(DONE), 16'd0);
            check("run_busy", 16'(BUSY), 16'd1);
        end
        @(negedge CLK);
        START = 1'b0;
        @(posedge CLK); #1;
        check("ignore_start_done", 16'(DONE), 16'd1);
        check("ignore_start_p", P, 16'h000F);
        done_cnt = 0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (DONE) done_cnt++;
        end
        check("no_second_done", 16'(done_cnt), 16'd0);

        // Asynchronous reset mid-run aborts and clears outputs immediately.
        @(negedge CLK);
        START = 1'b1;
        A     = 8'h10;
        B     = 8'h10;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (4) @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        check("abort_busy", 16'(BUSY), 16'd0);
        check("abort_done", 16'(DONE), 16'd0);
        check("abort_p", P, 16'h0000);
        check("abort_z", 16'(Z), 16'd1);
        done_cnt = 0;
        repeat (10) begin
            @(posedge CLK); #1;
            if (DONE) done_cnt++;
        end
        check("abort_no_done", 16'(done_cnt), 16'd0);
        @(negedge CLK);
        nRST = 1'b1;
        do_op(8'h10, 8'h10, 16'h0100, 1'b0, 1'b1, 16'h0000);

        // Back-to-back: START held high, second operation accepted in the DONE cycle.
        @(negedge CLK);
        START = 1'b1;
        A     = 8'h02;
        B     = 8'h03;
        @(posedge CLK); #1;
        done_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 1) begin
                A = 8'hAA;
                B = 8'h55;
            end
            @(posedge CLK); #1;
            if (DONE) done_cnt++;
        end
        check("b2b_first_done", 16'(DONE), 16'd1);
        check("b2b_first_p", P, 16'h0006);
        @(negedge CLK);
        A = 8'h04;
        B = 8'h05;
        @(posedge CLK); #1;
        START = 1'b0;
        check("b2b_accept_busy", 16'(BUSY), 16'd1);
        check("b2b_accept_done_low", 16'(DONE), 16'd0);
        for (int i = 10; i <= 17; i++) begin
            @(posedge CLK); #1;
            if (DONE) done_cnt++;
        end
        check("b2b_second_done", 16'(DONE), 16'd1);
        check("b2b_second_p", P, 16'h0014);
        repeat (5) begin
            @(posedge CLK); #1;
            if (DONE) done_cnt++;
        end
        check("b2b_done_pulses", 16'(done_cnt), 16'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
